// File: rtl/div.sv
// rtl/div.sv - 32-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional feature: define DIV_SIGNED_EN to honour signed_i (magnitude conversion and sign fix-up).
module div #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            signed_i,
  input  logic            req_i,
  output logic            ready_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] quotient_q, quotient_d;
  logic [XLEN-1:0] remainder_q, remainder_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [2*XLEN:0] work_sh;
  logic [XLEN:0]   diff;
  logic            fast_path;

  assign fast_path = (b_i == '0) || (a_i == '0);

`ifdef DIV_SIGNED_EN
  logic neg_a, neg_b;
  logic negq_q, negq_d, negr_q, negr_d;

  assign neg_a = signed_i & a_i[XLEN-1];
  assign neg_b = signed_i & b_i[XLEN-1];
  assign a_mag = neg_a ? -a_i : a_i;
  assign b_mag = neg_b ? -b_i : b_i;

  // Sign flags are only meaningful for the iterative path; fast-path results are final.
  always_comb begin
    negq_d = negq_q;
    negr_d = negr_q;
    if (state_q == S_IDLE) begin
      negq_d = fast_path ? 1'b0 : (neg_a ^ neg_b);
      negr_d = fast_path ? 1'b0 : neg_a;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (req_i) begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  assign quo_fix = negq_q ? -quo_q : quo_q;
  assign rem_fix = negr_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign a_mag   = a_i;
  assign b_mag   = b_i;
  assign quo_fix = quo_q;
  assign rem_fix = rem_q[XLEN-1:0];
`endif

  assign work_sh = {rem_q, quo_q} << 1;
  assign diff    = work_sh[2*XLEN:XLEN] - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (b_i == '0) begin
          quo_d   = '1;
          rem_d   = {1'b0, a_i};
          state_d = S_DONE;
        end else if (a_i == '0) begin
          quo_d   = '0;
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          cnt_d   = 6'(XLEN - 1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!diff[XLEN]) begin
          rem_d = diff;
          quo_d = {work_sh[XLEN-1:1], 1'b1};
        end else begin
          rem_d = work_sh[2*XLEN:XLEN];
          quo_d = work_sh[XLEN-1:0];
        end
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd0) state_d = S_DONE;
      end
      S_DONE: begin
        quotient_d  = quo_fix;
        remainder_d = rem_fix;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A low req_i aborts: back to idle, results from an unfinished op are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
    end else if (!req_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
    end
  end

  assign ready_o     = ready_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - randomized self-checking bench for div against an arithmetic reference model
module tb_div;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] a_i, b_i;
  logic        signed_i;
  logic        req_i;
  logic        ready_o;
  logic [31:0] quotient_o, remainder_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_q, last_r;

  div #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .a_i         (a_i),
    .b_i         (b_i),
    .signed_i    (signed_i),
    .req_i       (req_i),
    .ready_o     (ready_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    logic sg;
    logic [31:0] ma, mb;
`ifdef DIV_SIGNED_EN
    sg = s;
`else
    sg = 1'b0;
`endif
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      ma = (sg && a[31]) ? (32'd0 - a) : a;
      mb = (sg && b[31]) ? (32'd0 - b) : b;
      q  = ma / mb;
      r  = ma % mb;
      if (sg && (a[31] ^ b[31])) q = 32'd0 - q;
      if (sg && a[31])           r = 32'd0 - r;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit drop);
    logic [31:0] eq, er;
    int lat, k;
    a_i = a; b_i = b; signed_i = s; req_i = 1'b1;
    ref_div(a, b, s, eq, er);
    lat = (b == 32'd0 || a == 32'd0) ? 2 : 34;
    k = 0;
    do begin
      step();
      k++;
    end while (!ready_o && k < 100);
    check("latency", 32'(k), 32'(lat));
    check("quotient", quotient_o, eq);
    check("remainder", remainder_o, er);
    last_q = eq;
    last_r = er;
    if (drop) begin
      req_i = 1'b0;
      step();
      check("ready_after", {31'd0, ready_o}, 32'd0);
      check("hold_quotient", quotient_o, eq);
    end
  endtask

  initial begin
    bit seen;
    rst_ni = 1'b0; req_i = 1'b0; a_i = '0; b_i = '0; signed_i = 1'b0;
    repeat (3) step();
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_quotient", quotient_o, 32'd0);
    check("rst_remainder", remainder_o, 32'd0);
    rst_ni = 1'b1;
    step();

    run_op(32'd100, 32'd7, 1'b0, 1'b1);
    run_op(32'h0000_1234, 32'd0, 1'b0, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_op(32'd0, 32'd5, 1'b1, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1);

    // back-to-back: req_i stays high through the ready cycle
    run_op(32'd200, 32'd9, 1'b0, 1'b0);
    run_op(32'd1000, 32'd33, 1'b0, 1'b1);

    // abort in cycle 10, then re-issue
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; req_i = 1'b1;
    repeat (10) step();
    req_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready_o) seen = 1'b1;
    end
    check("abort_no_ready", {31'd0, seen}, 32'd0);
    check("abort_hold_q", quotient_o, last_q);
    check("abort_hold_r", remainder_o, last_r);
    run_op(32'd50, 32'd3, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      int mode;
      ra = $urandom;
      rb = $urandom;
      mode = $urandom_range(0, 5);
      case (mode)
        0: rb = 32'd0;
        1: ra = 32'd0;
        2: rb = 32'($urandom_range(1, 20));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end

    // reset in cycle 20 of an iterative op
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; req_i = 1'b1;
    repeat (20) step();
    rst_ni = 1'b0;
    step();
    check("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    check("mid_rst_quotient", quotient_o, 32'd0);
    check("mid_rst_remainder", remainder_o, 32'd0);
    seen = 1'b0;
    repeat (2) begin
      step();
      if (ready_o) seen = 1'b1;
    end
    req_i = 1'b0;
    rst_ni = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready_o) seen = 1'b1;
    end
    check("post_rst_no_ready", {31'd0, seen}, 32'd0);
    check("post_rst_quotient", quotient_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
